// File: rtl/posit_unpack_pipe.sv
// posit_unpack_pipe: two-stage pipelined posit decoder with valid/ready flow control.
// Stage 1 captures sign, special-value flags and the magnitude body (two's complement
// of negative words). Stage 2 decodes regime run length, exponent and fraction.
// Optional build macro POSIT_UNPACK_SCALE_EN adds the combined scale output
// out_scale = (regime << ES) + exp.
module posit_unpack_pipe #(
  parameter int BITS = 32,
  parameter int ES   = 3,
  localparam int RW  = $clog2(BITS) + 1,
  localparam int EW  = (ES > 0) ? ES : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITS-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [RW-1:0] out_regime,
  output logic [EW-1:0]        out_exp,
  output logic [BITS-1:0]      out_frac
`ifdef POSIT_UNPACK_SCALE_EN
  ,
  output logic signed [RW+ES-1:0] out_scale
`endif
);

  // Body width: the posit word without its sign bit.
  localparam int NB = BITS - 1;
`ifdef POSIT_UNPACK_SCALE_EN
  localparam int SW = RW + ES;
`endif

  // Stage 1 registers.
  logic          s1_valid;
  logic          s1_sign;
  logic          s1_zero;
  logic          s1_nar;
  logic [NB-1:0] s1_body;

  // Handshake and stage-1 combinational values.
  logic            s1_advance;
  logic            s2_advance;
  logic [BITS-1:0] mag;
  logic            zero_in;
  logic            nar_in;

  // Stage 2 decode results.
  logic          lead;
  logic          run_done;
  logic [RW-1:0] run;
  logic [NB-1:0] rest;
  logic [RW-1:0] dec_regime;
  logic [EW-1:0] dec_exp;
  logic [BITS-1:0] dec_frac;
`ifdef POSIT_UNPACK_SCALE_EN
  logic signed [SW-1:0] regime_ext;
  logic signed [SW-1:0] dec_scale;
`endif

  // A stage moves forward when it is empty or the stage downstream of it moves;
  // in_ready depends only on registered state and out_ready, never on in_valid.
  always_comb begin
    s2_advance = !out_valid || out_ready;
    s1_advance = !s1_valid || s2_advance;
    in_ready   = s1_advance;
  end

  // Stage 1 combinational: magnitude and special-value detection on the raw word.
  always_comb begin
    mag     = in_data[BITS-1] ? (-in_data) : in_data;
    zero_in = (in_data == '0);
    nar_in  = (in_data == {1'b1, {NB{1'b0}}});
  end

  // Stage 1 register: capture the word whenever the stage is free to advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_body  <= '0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_data[BITS-1];
        s1_zero <= zero_in;
        s1_nar  <= nar_in;
        s1_body <= mag[NB-1:0];
      end
    end
  end

  // Stage 2 combinational: regime run length, then exponent and fraction from
  // whatever body bits remain after the run and its terminator.
  always_comb begin
    lead     = s1_body[NB-1];
    run      = '0;
    run_done = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!run_done && (s1_body[i] == lead)) begin
        run = run + RW'(1);
      end else begin
        run_done = 1'b1;
      end
    end

    // Shifting past the body end (run fills the body) leaves zeros, which is
    // exactly the "missing bits read as 0" behaviour for exponent and fraction.
    rest = s1_body << (run + RW'(1));

    dec_regime = lead ? (run - RW'(1)) : (RW'(0) - run);

    dec_exp = '0;
    for (int i = 0; i < ES; i++) begin
      dec_exp[EW-1-i] = rest[NB-1-i];
    end

    dec_frac = {1'b1, NB'(rest << ES)};

    if (s1_zero || s1_nar) begin
      dec_regime = '0;
      dec_exp    = '0;
      dec_frac   = '0;
    end

`ifdef POSIT_UNPACK_SCALE_EN
    regime_ext = SW'($signed(dec_regime));
    dec_scale  = (regime_ext <<< ES) + $signed(SW'(dec_exp));
`endif
  end

  // Stage 2 register: outputs update only when downstream can take a new word,
  // so they hold stable throughout a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_nar    <= 1'b0;
      out_regime <= '0;
      out_exp    <= '0;
      out_frac   <= '0;
`ifdef POSIT_UNPACK_SCALE_EN
      out_scale  <= '0;
`endif
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign   <= s1_sign;
        out_zero   <= s1_zero;
        out_nar    <= s1_nar;
        out_regime <= $signed(dec_regime);
        out_exp    <= dec_exp;
        out_frac   <= dec_frac;
`ifdef POSIT_UNPACK_SCALE_EN
        out_scale  <= dec_scale;
`endif
      end
    end
  end

endmodule

// File: tb/tb_posit_unpack_pipe.sv
// tb_posit_unpack_pipe: directed bench for posit_unpack_pipe at BITS=8, ES=1.
// Expected decodes come from a constant table keyed by input word; a scoreboard
// queue carries them from input transfer to output transfer.
module tb_posit_unpack_pipe;

  localparam int BITS = 8;
  localparam int ES   = 1;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic       out_zero;
  logic       out_nar;
  logic [3:0] out_regime;
  logic [0:0] out_exp;
  logic [7:0] out_frac;
`ifdef POSIT_UNPACK_SCALE_EN
  logic [4:0] out_scale;
`endif

  typedef struct {
    logic [7:0] word;
    logic       sign;
    logic       zero;
    logic       nar;
    logic [3:0] regime;
    logic       exp;
    logic [7:0] frac;
    logic [4:0] scale;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t stall_e;

  int n_checks = 0;
  int n_fail   = 0;

  posit_unpack_pipe #(.BITS(BITS), .ES(ES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_zero   (out_zero),
    .out_nar    (out_nar),
    .out_regime (out_regime),
    .out_exp    (out_exp),
    .out_frac   (out_frac)
`ifdef POSIT_UNPACK_SCALE_EN
    ,
    .out_scale  (out_scale)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-decoded reference values for every word used in the bench.
  function automatic exp_t lookup(input logic [7:0] w);
    exp_t e;
    e = '{word: w, sign: 0, zero: 0, nar: 0, regime: 4'h0, exp: 0, frac: 8'h80, scale: 5'h00};
    case (w)
      8'h40: ;
      8'h6C: begin e.regime = 4'h1; e.exp = 1; e.frac = 8'hC0; e.scale = 5'h03; end
      8'hC0: begin e.sign = 1; end
      8'h7F: begin e.regime = 4'h6; e.scale = 5'h0C; end
      8'h01: begin e.regime = 4'hA; e.scale = 5'h14; end
      8'h00: begin e.zero = 1; e.frac = 8'h00; end
      8'h80: begin e.sign = 1; e.nar = 1; e.frac = 8'h00; end
      8'h50: begin e.exp = 1; e.scale = 5'h01; end
      8'h90: begin e.sign = 1; e.regime = 4'h2; e.scale = 5'h04; end
      8'h30: begin e.regime = 4'hF; e.exp = 1; e.scale = 5'h1F; end
      8'h4B: begin e.frac = 8'hD8; end
      default: begin e.sign = 1'bx; end
    endcase
    return e;
  endfunction

  // One comparison: counts it, and counts and reports a failure.
  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every field of the current output against one expected entry.
  task automatic check_fields(input string tag, input exp_t e);
    check_output($sformatf("%s_sign_%h", tag, e.word), 64'(out_sign), 64'(e.sign));
    check_output($sformatf("%s_zero_%h", tag, e.word), 64'(out_zero), 64'(e.zero));
    check_output($sformatf("%s_nar_%h", tag, e.word), 64'(out_nar), 64'(e.nar));
    check_output($sformatf("%s_regime_%h", tag, e.word), 64'(out_regime), 64'(e.regime));
    check_output($sformatf("%s_exp_%h", tag, e.word), 64'(out_exp), 64'(e.exp));
    check_output($sformatf("%s_frac_%h", tag, e.word), 64'(out_frac), 64'(e.frac));
`ifdef POSIT_UNPACK_SCALE_EN
    check_output($sformatf("%s_scale_%h", tag, e.word), 64'(out_scale), 64'(e.scale));
`endif
  endtask

  // Drive one word and hold it until accepted; push its expectation on transfer.
  task automatic apply_stimulus(input logic [7:0] w);
    bit accepted;
    accepted = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(lookup(w));
        accepted = 1;
        break;
      end
    end
    if (!accepted) check_output($sformatf("accept_timeout_%h", w), 64'(accepted), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait, with a cycle budget, for every pushed expectation to be consumed.
  task automatic wait_drain(input string tag);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check_output(tag, 64'(sb_q.size()), 64'(0));
  endtask

  // Output monitor: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check_fields("out", mon_e);
      end
    end
  end

  // Overall time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] bp_words [4];
  logic [7:0] dir_words [10];
  int  idx;
  bit  saw_low;

  initial begin
    bp_words  = '{8'h50, 8'h90, 8'h30, 8'h4B};
    dir_words = '{8'h6C, 8'hC0, 8'h7F, 8'h01, 8'h00, 8'h80, 8'h50, 8'h90, 8'h30, 8'h4B};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_out_valid", 64'(out_valid), 64'(0));
    check_output("reset_in_ready", 64'(in_ready), 64'(1));
    check_output("reset_frac", 64'(out_frac), 64'(0));
    check_output("reset_regime", 64'(out_regime), 64'(0));
    @(posedge clk);
    #1;

    // Latency: a lone word appears on the second cycle after its transfer.
    $display("[TB] latency check with 8'h40");
    apply_stimulus(8'h40);
    @(negedge clk);
    check_output("latency_not_yet", 64'(out_valid), 64'(0));
    @(negedge clk);
    check_output("latency_valid", 64'(out_valid), 64'(1));
    wait_drain("drain_latency");

    // Directed words back to back, including boundary runs and specials.
    $display("[TB] directed stream");
    @(posedge clk);
    #1;
    foreach (dir_words[i]) apply_stimulus(dir_words[i]);
    wait_drain("drain_directed");

    // Backpressure: four back-to-back words, downstream stalled in cycles 3..5.
    $display("[TB] backpressure stream");
    @(posedge clk);
    #1;
    idx     = 0;
    saw_low = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (idx < 4) begin
        in_valid = 1'b1;
        in_data  = bp_words[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!in_ready) saw_low = 1;
      if (out_valid && !out_ready && sb_q.size() > 0) begin
        stall_e = sb_q[0];
        check_fields("stall", stall_e);
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(lookup(bp_words[idx]));
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output("bp_in_ready_dropped", 64'(saw_low), 64'(1));
    check_output("bp_all_accepted", 64'(idx), 64'(4));
    wait_drain("drain_backpressure");

    // Reset with two words in flight: neither may ever be emitted.
    $display("[TB] reset mid-stream");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    apply_stimulus(8'h6C);
    apply_stimulus(8'hC0);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("midreset_out_valid", 64'(out_valid), 64'(0));
    check_output("midreset_in_ready", 64'(in_ready), 64'(1));
    check_output("midreset_frac", 64'(out_frac), 64'(0));
    check_output("midreset_sign", 64'(out_sign), 64'(0));
    check_output("midreset_regime", 64'(out_regime), 64'(0));
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_output($sformatf("midreset_quiet_%0d", c), 64'(out_valid), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
